// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for the shared single-MAC FIR datapath: shift, walk taps, drain, emit result.
// Optional GAIN_SHIFT_EN adds a gain input that arithmetically right-shifts the result.
module fir_tap_sequencer #(
  parameter int NUM_TAPS = 10,
  parameter int ACC_W    = 33,
  parameter int MAC_LAT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
`ifdef GAIN_SHIFT_EN
  input  logic [3:0]       gain,
`endif
  output logic             win_shift,
  output logic [7:0]       tap_idx,
  output logic             mac_clr,
  output logic             mac_en,
  input  logic [ACC_W-1:0] result_i,
  output logic [ACC_W-1:0] result_o,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
);

  // state | meaning
  // IDLE  | waiting for sample_valid
  // SHIFT | pulse win_shift, restart tap index
  // RUN   | one tap per cycle through the MAC
  // DRAIN | wait for the MAC pipeline to settle
  // OUT   | result_o valid, result_valid strobe
  typedef enum logic [2:0] {IDLE, SHIFT, RUN, DRAIN, OUT} state_t;

  localparam logic [7:0] LAST_TAP   = 8'(NUM_TAPS - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(MAC_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] drain_cnt;
  logic [ACC_W-1:0] result_nxt;

`ifdef GAIN_SHIFT_EN
  logic [3:0] gain_q;
  assign result_nxt = $unsigned($signed(result_i) >>> gain_q);
`else
  assign result_nxt = result_i;
`endif

  always_comb begin
    state_nxt    = state;
    win_shift    = 1'b0;
    mac_en       = 1'b0;
    mac_clr      = 1'b0;
    result_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:  if (sample_valid) state_nxt = SHIFT;
      SHIFT: begin
        win_shift = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        mac_en  = 1'b1;
        mac_clr = (tap_idx == 8'd0);
        if (tap_idx == LAST_TAP) state_nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == 3'd0) state_nxt = OUT;
      OUT: begin
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tap_idx   <= 8'd0;
      drain_cnt <= 3'd0;
      result_o  <= '0;
      overrun   <= 1'b0;
`ifdef GAIN_SHIFT_EN
      gain_q    <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      // Samples are only taken in IDLE; anything else is a drop.
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        SHIFT: begin
          tap_idx <= 8'd0;
`ifdef GAIN_SHIFT_EN
          gain_q  <= gain;
`endif
        end
        RUN: begin
          if (tap_idx == LAST_TAP) drain_cnt <= DRAIN_INIT;
          else                     tap_idx   <= tap_idx + 8'd1;
        end
        DRAIN: begin
          if (drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
          else                   result_o  <= result_nxt;
        end
        OUT:     tap_idx <= 8'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: stimulus pushes expected events, a monitor pops on DUT strobes.
// Define GAIN_SHIFT_EN for both files to exercise the gain path.
module tb_fir_tap_sequencer;
  localparam int ACC_W = 33;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_valid = 1'b0;
  logic             win_shift, mac_clr, mac_en, result_valid, busy, overrun;
  logic [7:0]       tap_idx;
  logic [ACC_W-1:0] result_i, result_o;
`ifdef GAIN_SHIFT_EN
  logic [3:0]       gain = 4'd0;
`endif

  fir_tap_sequencer #(.NUM_TAPS(10), .ACC_W(ACC_W), .MAC_LAT(2)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
`ifdef GAIN_SHIFT_EN
    .gain(gain),
`endif
    .win_shift(win_shift), .tap_idx(tap_idx), .mac_clr(mac_clr), .mac_en(mac_en),
    .result_i(result_i), .result_o(result_o), .result_valid(result_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC model: tap 0 contributes mac_w, tap k contributes k; one extra register gives MAC_LAT=2.
  logic [ACC_W-1:0] mac_w = '0;
  logic [ACC_W-1:0] acc = '0;
  logic [ACC_W-1:0] res_d = '0;
  logic [ACC_W-1:0] term;
  assign term = (tap_idx == 8'd0) ? mac_w : {25'd0, tap_idx};
  always @(posedge clk) begin
    if (mac_en) acc <= mac_clr ? term : acc + term;
    res_d <= acc;
  end
  assign result_i = res_d;

  typedef struct { int cyc; int tap; } tap_ev_t;
  typedef struct { int cyc; logic [ACC_W-1:0] val; } res_ev_t;
  int      win_q[$];
  tap_ev_t tap_q[$];
  res_ev_t res_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endfunction

  bit      mon_on = 1'b0;
  bit      prev_rv = 1'b0;
  tap_ev_t te;
  res_ev_t re;
  always @(negedge clk) begin
    if (mon_on) begin
      if (win_shift) begin
        if (win_q.size() == 0) chk("win_shift unexpected", win_shift, 0);
        else chk("win_shift cycle", cyc, win_q.pop_front());
      end
      if (mac_en) begin
        if (tap_q.size() == 0) chk("mac_en unexpected", mac_en, 0);
        else begin
          te = tap_q.pop_front();
          chk("tap cycle", cyc, te.cyc);
          chk("tap_idx", tap_idx, te.tap);
          chk("mac_clr", mac_clr, te.tap == 0);
        end
      end else chk("mac_clr without mac_en", mac_clr, 0);
      if (result_valid) begin
        if (res_q.size() == 0) chk("result_valid unexpected", result_valid, 0);
        else begin
          re = res_q.pop_front();
          chk("result_valid cycle", cyc, re.cyc);
          chk("result_o", result_o, re.val);
        end
      end
      chk("tap_idx range", tap_idx > 8'd9, 0);
      chk("result_valid back-to-back", result_valid && prev_rv, 0);
      prev_rv = result_valid;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse();
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic expect_sample(int b, int ntaps, bit with_res, logic [ACC_W-1:0] v);
    win_q.push_back(b + 1);
    for (int i = 0; i < ntaps; i++) tap_q.push_back('{b + 2 + i, i});
    if (with_res) res_q.push_back('{b + 14, v});
  endtask

  task automatic chk_drained(string name);
    chk(name, win_q.size() + tap_q.size() + res_q.size(), 0);
  endtask

  int b, b2;
  initial begin
    tick(1);
    do_reset();
    mon_on = 1'b1;
    chk("reset busy", busy, 0);
    chk("reset tap_idx", tap_idx, 0);
    chk("reset result_o", result_o, 0);
    chk("reset overrun", overrun, 0);

    // single sample
    b = cyc; mac_w = 33'h1207;
    expect_sample(b, 10, 1, 33'h1234);
    pulse(); tick(20);
    chk_drained("single: scoreboard empty");
    chk("single: overrun", overrun, 0);

    // back-to-back at minimum spacing
    b = cyc; mac_w = 33'h100;
    expect_sample(b, 10, 1, 33'h12D);
    pulse(); tick(14);
    b2 = cyc; mac_w = 33'h2000;
    chk("b2b: spacing", b2 - b, 15);
    expect_sample(b2, 10, 1, 33'h202D);
    pulse(); tick(20);
    chk_drained("b2b: scoreboard empty");
    chk("b2b: overrun", overrun, 0);

    // drop during RUN
    b = cyc; mac_w = 33'h3000;
    expect_sample(b, 10, 1, 33'h302D);
    pulse(); tick(7);
    chk("run drop: overrun before", overrun, 0);
    pulse();
    chk("run drop: overrun at cycle 9", overrun, 1);
    tick(20);
    chk("run drop: overrun sticky", overrun, 1);
    chk_drained("run drop: scoreboard empty");

    do_reset();
    chk("reset clears overrun", overrun, 0);
    chk("reset clears result_o", result_o, 0);

    // drop during OUT, accept on the following IDLE cycle
    b = cyc; mac_w = 33'h40;
    expect_sample(b, 10, 1, 33'h6D);
    pulse(); tick(13);
    pulse();
    chk("out drop: overrun", overrun, 1);
    b2 = cyc; mac_w = 33'h50;
    expect_sample(b2, 10, 1, 33'h7D);
    pulse(); tick(20);
    chk_drained("out drop: scoreboard empty");

    // reset during RUN at tap 4
    b = cyc; mac_w = 33'h99;
    expect_sample(b, 5, 0, '0);
    pulse(); tick(5);
    reset = 1'b1;
    tick(1);
    chk("mid reset busy", busy, 0);
    chk("mid reset tap_idx", tap_idx, 0);
    chk("mid reset mac_en", mac_en, 0);
    chk("mid reset result_o", result_o, 0);
    chk("mid reset overrun", overrun, 0);
    reset = 1'b0;
    tick(20);
    chk("mid reset result_o held", result_o, 0);
    chk_drained("mid reset: scoreboard empty");

`ifdef GAIN_SHIFT_EN
    b = cyc; mac_w = 33'h1_0000_0ED3; gain = 4'd4;
    expect_sample(b, 10, 1, 33'h1_F000_00F0);
    pulse(); tick(4);
    gain = 4'd0;
    tick(20);
    chk_drained("gain: scoreboard empty");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
